// File: rtl/control_filtropa20_if.sv
// Control bundle between the control_filtropa20 sequencer and its
// host/datapath. The master side is the sequencer: it consumes the sample
// strobe and drives the register enables, mux selects and status. The slave
// side is the host that supplies start/clr_ovr and the filtropa20 datapath
// that observes the controls.
interface control_filtropa20_if;
   logic       start;
   logic       clr_ovr;
   logic       en1;
   logic       en2;
   logic       en3;
   logic       en4;
   logic [2:0] muxS;
   logic [1:0] muxC;
   logic [1:0] muxZ;
   logic       busy;
   logic       done;
   logic       overrun;
   logic [2:0] step;

   modport master (
      input  start, clr_ovr,
      output en1, en2, en3, en4, muxS, muxC, muxZ, busy, done, overrun, step
   );

   modport slave (
      output start, clr_ovr,
      input  en1, en2, en3, en4, muxS, muxC, muxZ, busy, done, overrun, step
   );
endinterface

// File: rtl/control_filtropa20.sv
// Sequencer for the filtropa20 second-order high-pass datapath.
// One sample per start strobe: shift the F history, build F(K) in two
// accumulate steps, then build Y(K) in three accumulate steps.
// Each arithmetic step lasts 1+WAIT_CYC cycles; its register enable fires
// only in the last cycle, so the mux selects settle for WAIT_CYC cycles first.
// All outputs are decoded from the registered state and counter only.
// Optional feature: define OVERRUN_DET_EN to enable the sticky overrun flag
// (start seen while busy); without it overrun is tied to 0.
module control_filtropa20 #(
   parameter int unsigned WAIT_CYC = 0
) (
   input logic                  clk,
   input logic                  reset,
   control_filtropa20_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      F1    = 3'd2,
      F2    = 3'd3,
      Y1    = 3'd4,
      Y2    = 3'd5,
      Y3    = 3'd6,
      DONE  = 3'd7
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       last_c;
   logic       busy_c;

   // final settle cycle of the current arithmetic step
   assign last_c = (cnt_q == WAIT_LAST);

   // state and settle counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state; counter restarts at 0 on every state entry
   always_comb begin
      state_d = state_q;
      cnt_d   = 4'd0;
      case (state_q)
         IDLE:  if (bus.start) state_d = SHIFT;
         SHIFT: state_d = F1;
         F1:    if (last_c) state_d = F2; else cnt_d = cnt_q + 4'd1;
         F2:    if (last_c) state_d = Y1; else cnt_d = cnt_q + 4'd1;
         Y1:    if (last_c) state_d = Y2; else cnt_d = cnt_q + 4'd1;
         Y2:    if (last_c) state_d = Y3; else cnt_d = cnt_q + 4'd1;
         Y3:    if (last_c) state_d = DONE; else cnt_d = cnt_q + 4'd1;
         DONE:  state_d = bus.start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath controls decoded from registered state and counter
   always_comb begin
      bus.en1  = 1'b0;
      bus.en2  = 1'b0;
      bus.en3  = 1'b0;
      bus.en4  = 1'b0;
      bus.muxS = 3'd0;
      bus.muxC = 2'd0;
      bus.muxZ = 2'd0;
      bus.done = 1'b0;
      busy_c   = 1'b0;
      case (state_q)
         SHIFT: begin
            // FK_1 <= FK and FK_2 <= FK_1 in the same edge
            busy_c  = 1'b1;
            bus.en3 = 1'b1;
            bus.en4 = 1'b1;
         end
         F1: begin
            busy_c   = 1'b1;
            bus.muxC = 2'd1;
            bus.muxZ = 2'd1;
            bus.en2  = last_c;
         end
         F2: begin
            busy_c   = 1'b1;
            bus.muxS = 3'd1;
            bus.muxC = 2'd2;
            bus.muxZ = 2'd2;
            bus.en2  = last_c;
         end
         Y1: begin
            busy_c   = 1'b1;
            bus.muxS = 3'd2;
            bus.en1  = last_c;
         end
         Y2: begin
            busy_c   = 1'b1;
            bus.muxS = 3'd3;
            bus.muxC = 2'd1;
            bus.muxZ = 2'd1;
            bus.en1  = last_c;
         end
         Y3: begin
            busy_c   = 1'b1;
            bus.muxS = 3'd3;
            bus.muxC = 2'd2;
            bus.muxZ = 2'd2;
            bus.en1  = last_c;
         end
         DONE:    bus.done = 1'b1;
         default: busy_c   = 1'b0;
      endcase
   end

   assign bus.busy = busy_c;
   assign bus.step = state_q;

`ifdef OVERRUN_DET_EN
   logic ovr_q;

   // sticky overrun: a start seen while busy sets it, set beats clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr_q <= 1'b0;
      end else if (bus.start && busy_c) begin
         ovr_q <= 1'b1;
      end else if (bus.clr_ovr) begin
         ovr_q <= 1'b0;
      end
   end

   assign bus.overrun = ovr_q;
`else
   logic clr_ovr_unused;

   assign clr_ovr_unused = bus.clr_ovr;
   assign bus.overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_control_filtropa20.sv
// Directed bench for control_filtropa20: one instance with WAIT_CYC=0 and
// one with WAIT_CYC=2, each on its own interface, checked cycle by cycle
// against hand-written control tables.
module tb_control_filtropa20;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   control_filtropa20_if bus0 ();
   control_filtropa20_if bus2 ();

   control_filtropa20 #(.WAIT_CYC(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   control_filtropa20 #(.WAIT_CYC(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

`ifdef OVERRUN_DET_EN
   localparam logic OVR = 1'b1;
`else
   localparam logic OVR = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // WAIT_CYC=0 expected controls for cycles 1..8 after the start edge.
   // en is packed {en1,en2,en3,en4}.
   logic [2:0] t_step [1:8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
   logic [3:0] t_en   [1:8] = '{4'h3, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
   logic [2:0] t_s    [1:8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0};
   logic [1:0] t_c    [1:8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
   logic [1:0] t_z    [1:8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
   logic       t_busy [1:8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic       t_done [1:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   // Per arithmetic state F1,F2,Y1,Y2,Y3: mux selects and final-cycle enable
   logic [2:0] a_s  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
   logic [1:0] a_c  [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
   logic [3:0] a_en [5] = '{4'h4, 4'h4, 4'h8, 4'h8, 4'h8};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] mkw(input logic [2:0] st, input logic [3:0] en,
                                       input logic [2:0] s, input logic [1:0] c,
                                       input logic [1:0] z, input logic b, input logic d);
      return {st, en, s, c, z, b, d};
   endfunction

   function automatic logic [15:0] w0();
      return {bus0.step, bus0.en1, bus0.en2, bus0.en3, bus0.en4,
              bus0.muxS, bus0.muxC, bus0.muxZ, bus0.busy, bus0.done};
   endfunction

   function automatic logic [15:0] w2();
      return {bus2.step, bus2.en1, bus2.en2, bus2.en3, bus2.en4,
              bus2.muxS, bus2.muxC, bus2.muxZ, bus2.busy, bus2.done};
   endfunction

   // One full sample on dut0 from IDLE; optional extra start pulse in cycle pulse_cyc.
   task automatic run_seq0(input string nm, input int pulse_cyc);
      bus0.start = 1'b1;
      tick();
      for (int c = 1; c <= 8; c++) begin
         bus0.start = (c == pulse_cyc);
         check($sformatf("%s_c%0d", nm, c), 32'(w0()),
               32'(mkw(t_step[c], t_en[c], t_s[c], t_c[c], t_z[c], t_busy[c], t_done[c])));
         if (pulse_cyc != 0)
            check($sformatf("%s_ovr_c%0d", nm, c), 32'(bus0.overrun),
                  32'(OVR && (c > pulse_cyc)));
         if (c < 8) tick();
      end
      bus0.start = 1'b0;
   endtask

   // One full sample on dut2 (WAIT_CYC=2); DONE lands in cycle 17.
   task automatic run_seq2();
      int cyc;
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      cyc = 1;
      check("w2_c1", 32'(w2()), 32'(mkw(3'd1, 4'h3, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0)));
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 3; j++) begin
            tick();
            cyc++;
            check($sformatf("w2_c%0d", cyc), 32'(w2()),
                  32'(mkw(3'(2 + k), (j == 2) ? a_en[k] : 4'h0, a_s[k], a_c[k], a_c[k],
                          1'b1, 1'b0)));
         end
      end
      tick();
      check("w2_done_c17", 32'(w2()), 32'(mkw(3'd7, 4'h0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1)));
      tick();
      check("w2_idle_c18", 32'(w2()), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      int idl;
      reset        = 1'b1;
      bus0.start   = 1'b0;
      bus0.clr_ovr = 1'b0;
      bus2.start   = 1'b0;
      bus2.clr_ovr = 1'b0;
      #2;
      check("rst_w0", 32'(w0()), 32'h0);
      check("rst_ovr0", 32'(bus0.overrun), 32'h0);
      check("rst_w2", 32'(w2()), 32'h0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("idle_w0", 32'(w0()), 32'h0);

      // basic sequence, WAIT_CYC=0
      run_seq0("seq", 0);

      // WAIT_CYC=2 timing
      run_seq2();

      // start pulse in cycle 3 is ignored by the sequence, flags overrun
      run_seq0("ovr", 3);
      bus0.clr_ovr = 1'b1;
      tick();
      bus0.clr_ovr = 1'b0;
      check("clr_ovr", 32'(bus0.overrun), 32'h0);

      // start and clr_ovr together while busy: set wins
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      tick();
      bus0.start   = 1'b1;
      bus0.clr_ovr = 1'b1;
      tick();
      bus0.start   = 1'b0;
      bus0.clr_ovr = 1'b0;
      check("setwins_ovr", 32'(bus0.overrun), 32'(OVR));
      check("setwins_step", 32'(bus0.step), 32'd3);
      bus0.clr_ovr = 1'b1;
      tick();
      bus0.clr_ovr = 1'b0;
      check("clr2_ovr", 32'(bus0.overrun), 32'h0);
      check("clr2_step", 32'(bus0.step), 32'd4);
      repeat (3) tick();
      check("setwins_done", 32'(w0()), 32'(mkw(3'd7, 4'h0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1)));
      tick();
      check("setwins_idle", 32'(w0()), 32'h0);

      // start held high: DONE chains straight into SHIFT
      bus0.start = 1'b1;
      tick();
      dn  = 0;
      idl = 0;
      for (int i = 0; i < 21; i++) begin
         check($sformatf("cont_step%0d", i), 32'(bus0.step), 32'((i % 7) + 1));
         dn  += int'(bus0.done);
         idl += int'(bus0.step == 3'd0);
         if (i < 20) tick();
      end
      bus0.start = 1'b0;
      check("cont_done_cnt", 32'(dn), 32'd3);
      check("cont_idle_cnt", 32'(idl), 32'd0);
      tick();
      check("cont_idle", 32'(w0()), 32'h0);

      // reset during Y2 aborts immediately
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      repeat (4) tick();
      check("abort_y2_step", 32'(bus0.step), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      check("abort_w0", 32'(w0()), 32'h0);
      check("abort_ovr", 32'(bus0.overrun), 32'h0);
      tick();
      tick();
      check("abort_held_w0", 32'(w0()), 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("post_abort_en1_%0d", i), 32'(bus0.en1), 32'h0);
         check($sformatf("post_abort_step_%0d", i), 32'(bus0.step), 32'h0);
      end

      // first start after reset runs a complete sequence
      run_seq0("after", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
